// File: rtl/fir_pkg.sv
// Shared types and helpers for the FIR filter bank: FSM state encoding,
// mode numbering, accumulator width and output saturation.
// Pure declarations; no clocked logic.
package fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Conventional meaning of each coefficient set
    localparam int MODE_LP = 0;
    localparam int MODE_HP = 1;
    localparam int MODE_BP = 2;
    localparam int MODE_MA = 3;

    // Full-precision accumulator: product width plus growth for TAPS additions
    function automatic int acc_w(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

    // Clamp a signed value into the range of a w-bit two's complement number
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Multiply-accumulate datapath with round-half-up, arithmetic shift and saturation.
// Latency: product registered one cycle after mul_en, accumulated the cycle after; fin_en folds the last product in.
// Backpressure: none here; the controlling FSM holds out_data by not pulsing fin_en.
//
// Ports: clr zeroes the accumulator for a new sample; mul_en issues one tap (x*h);
// fin_en loads out_data from the accumulator including any product still in flight.
module fir_mac_unit
    import fir_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 16,
    parameter int FRAC   = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     mul_en,
    input  logic                     fin_en,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [COEF_W-1:0] h,
    output logic signed [DATA_W-1:0] out_data
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = acc_w(DATA_W, COEF_W, TAPS);
    // Rounding constant: half an output LSB (FRAC must be at least 1)
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) <<< (FRAC - 1);

    logic signed [PROD_W-1:0] prod_q;
    logic                     prod_vld_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_nxt;
    logic signed [ACC_W-1:0]  rnd;
    logic signed [DATA_W-1:0] sat_val;

    always_comb begin
        acc_nxt = acc_q;
        if (prod_vld_q) begin
            acc_nxt = acc_q + ACC_W'(prod_q);
        end
        rnd     = (acc_nxt + HALF) >>> FRAC;
        sat_val = DATA_W'(saturate(64'(rnd), DATA_W));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            acc_q      <= '0;
            out_data   <= '0;
        end else begin
            if (clr) begin
                prod_vld_q <= 1'b0;
                acc_q      <= '0;
            end else begin
                prod_vld_q <= mul_en;
                acc_q      <= acc_nxt;
            end
            if (mul_en) begin
                prod_q <= x * h;
            end
            if (fin_en) begin
                out_data <= sat_val;
            end
        end
    end

endmodule

// File: rtl/fir_filter_bank.sv
// Time-multiplexed FIR engine with NUM_MODES runtime-loadable coefficient sets chosen per sample.
// Latency: sample accepted at edge T gives out_valid after edge T+TAPS+1; one sample in flight at a time.
// Backpressure: in_ready low from accept until the result handshakes; out_data held while out_ready is low.
//
// Ports: in_data/in_mode/in_valid/in_ready  sample stream in
//        out_data/out_valid/out_ready        filtered result out
//        coef_we/coef_mode/coef_idx/coef_data/coef_busy  coefficient write port (idx 0 = newest sample)
module fir_filter_bank
    import fir_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int TAPS      = 16,
    parameter int NUM_MODES = 4,
    parameter int FRAC      = 15,
    localparam int MODE_W   = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1,
    localparam int IDX_W    = $clog2(TAPS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic [MODE_W-1:0]        in_mode,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic                     coef_we,
    input  logic [MODE_W-1:0]        coef_mode,
    input  logic [IDX_W-1:0]         coef_idx,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic                     coef_busy
);

    localparam int DEPTH  = NUM_MODES * TAPS;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_TAP = IDX_W'(TAPS - 1);

    state_t                   state_q;
    state_t                   state_nxt;
    logic [IDX_W-1:0]         cnt_q;
    logic [MODE_W-1:0]        mode_q;
    logic [MODE_W-1:0]        mode_eff;
    logic                     out_valid_q;
    logic signed [DATA_W-1:0] x_q [TAPS];
    logic signed [COEF_W-1:0] coef_mem [DEPTH];

    logic                     accept;
    logic                     coef_mode_ok;
    logic                     coef_wr;
    logic [ADDR_W-1:0]        rd_addr;
    logic [ADDR_W-1:0]        wr_addr;
    logic signed [COEF_W-1:0] h_cur;
    logic                     mul_en;
    logic                     fin_en;

    // Out-of-range modes fall back to the LP set; writes to a nonexistent set are dropped.
    generate
        if (NUM_MODES == (1 << MODE_W)) begin : g_full_modes
            assign mode_eff     = in_mode;
            assign coef_mode_ok = 1'b1;
        end else begin : g_partial_modes
            assign mode_eff     = (int'(in_mode) < NUM_MODES) ? in_mode : MODE_W'(MODE_LP);
            assign coef_mode_ok = int'(coef_mode) < NUM_MODES;
        end
    endgenerate

    assign in_ready  = (state_q == ST_IDLE);
    assign accept    = in_ready && in_valid;
    // A sample offered in IDLE takes priority over a coefficient write
    assign coef_wr   = coef_we && (state_q == ST_IDLE) && !in_valid;
    assign coef_busy = coef_we && !coef_wr;

    assign rd_addr = ADDR_W'(int'(mode_q) * TAPS + int'(cnt_q));
    assign wr_addr = ADDR_W'(int'(coef_mode) * TAPS + int'(coef_idx));
    assign h_cur   = coef_mem[rd_addr];

    assign mul_en = (state_q == ST_MAC);
    // First OUT cycle drains the last product into out_data; afterwards the result is held
    assign fin_en = (state_q == ST_OUT) && !out_valid_q;

    assign out_valid = out_valid_q;

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: if (in_valid) state_nxt = ST_MAC;
            ST_MAC:  if (cnt_q == LAST_TAP) state_nxt = ST_OUT;
            ST_OUT:  if (out_valid_q && out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mode_q      <= '0;
            out_valid_q <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                x_q[k] <= '0;
            end
        end else begin
            state_q <= state_nxt;
            if (accept) begin
                x_q[0] <= in_data;
                for (int k = 1; k < TAPS; k++) begin
                    x_q[k] <= x_q[k-1];
                end
                mode_q <= mode_eff;
                cnt_q  <= '0;
            end else if ((state_q == ST_MAC) && (cnt_q != LAST_TAP)) begin
                cnt_q <= cnt_q + IDX_W'(1);
            end
            if (fin_en) begin
                out_valid_q <= 1'b1;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // Coefficient store is deliberately not reset
    always_ff @(posedge clk) begin
        if (coef_wr && coef_mode_ok) begin
            coef_mem[wr_addr] <= coef_data;
        end
    end

    fir_mac_unit #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .TAPS   (TAPS),
        .FRAC   (FRAC)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .clr      (accept),
        .mul_en   (mul_en),
        .fin_en   (fin_en),
        .x        (x_q[cnt_q]),
        .h        (h_cur),
        .out_data (out_data)
    );

endmodule

// File: tb/tb_fir_filter_bank.sv
module tb_fir_filter_bank;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [15:0] in_data = '0;
    logic [1:0]         in_mode = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] out_data;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic               coef_we = 1'b0;
    logic [1:0]         coef_mode = '0;
    logic [3:0]         coef_idx = '0;
    logic signed [15:0] coef_data = '0;
    logic               coef_busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int t_acc = 0;

    logic signed [15:0] m_hist [16];
    logic signed [15:0] m_coef [4][16];
    logic signed [15:0] exp_q [$];

    fir_filter_bank dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .coef_we   (coef_we),
        .coef_mode (coef_mode),
        .coef_idx  (coef_idx),
        .coef_data (coef_data),
        .coef_busy (coef_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: 16-tap FIR, round half up, shift 15, clamp to 16 bits
    function automatic logic signed [15:0] model_calc(input int mode);
        longint acc;
        longint r;
        acc = 0;
        for (int k = 0; k < 16; k++) acc += longint'(m_hist[k]) * longint'(m_coef[mode][k]);
        r = (acc + 64'sd16384) >>> 15;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return 16'(r);
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 16; k++) m_hist[k] = '0;
    endtask

    task automatic model_accept(input logic signed [15:0] d, input int mode, input bit track);
        for (int k = 15; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = d;
        if (track) exp_q.push_back(model_calc(mode));
    endtask

    task automatic pulse_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic write_coef(input int mode, input int idx, input logic signed [15:0] d);
        @(negedge clk);
        coef_we = 1'b1;
        coef_mode = 2'(mode);
        coef_idx = 4'(idx);
        coef_data = d;
        @(posedge clk);
        #1;
        coef_we = 1'b0;
        m_coef[mode][idx] = d;
    endtask

    // k=0 gets h0; with alt set, odd taps are 0 and even taps alternate sign
    task automatic load_set(input int mode, input logic signed [15:0] h0,
                            input logic signed [15:0] rest, input bit alt);
        logic signed [15:0] v;
        for (int k = 0; k < 16; k++) begin
            if (k == 0) v = h0;
            else if (!alt) v = rest;
            else if (k % 2 == 1) v = '0;
            else if (k % 4 == 2) v = -rest;
            else v = rest;
            write_coef(mode, k, v);
        end
    endtask

    task automatic send(input logic signed [15:0] d, input int mode, input bit track);
        int n;
        @(negedge clk);
        in_data = d;
        in_mode = 2'(mode);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            errors++;
            checks++;
            $display("FAIL send_ready: in_ready=%0b after %0d cycles, required 1", in_ready, n);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_mode = 2'(mode + 1);   // changing mode mid-MAC must have no effect
            t_acc = cyc;
            model_accept(d, mode, track);
        end
    endtask

    task automatic get_out(input string name, output logic signed [15:0] got, output int lat);
        int n;
        logic signed [15:0] e;
        got = 'x;
        lat = -1;
        @(negedge clk);
        n = 0;
        while (!out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL %s_timeout: out_valid=%0b, required 1 within 60 cycles", name, out_valid);
        end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_unexpected: out_data=%0d with empty scoreboard", name, out_data);
        end else begin
            e = exp_q.pop_front();
            got = out_data;
            lat = cyc - t_acc;
            if (out_data !== e) begin
                errors++;
                $display("FAIL %s_data: out_data=%0d, required %0d", name, out_data, e);
            end
            @(posedge clk);
        end
    endtask

    task automatic test_reset();
        pulse_reset(3);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b, required 0", out_valid); end
        checks++; if (out_data !== 16'sd0) begin errors++; $display("FAIL reset_out_data: got %0d, required 0", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b, required 1", in_ready); end
        checks++; if (coef_busy !== 1'b0) begin errors++; $display("FAIL reset_coef_busy: got %0b, required 0", coef_busy); end
    endtask

    task automatic test_impulse();
        logic signed [15:0] got;
        int lat;
        load_set(0, 16'sh7FFF, 16'sd0, 1'b0);
        send(16'sd1000, 0, 1'b1);
        get_out("impulse_first", got, lat);
        checks++; if (got !== 16'sd1000) begin errors++; $display("FAIL impulse_value: got %0d, required 1000", got); end
        checks++; if (lat !== 17) begin errors++; $display("FAIL impulse_latency: out_valid after edge T+%0d, required T+17", lat); end
        for (int i = 0; i < 4; i++) begin
            send(16'sd0, 0, 1'b1);
            get_out("impulse_tail", got, lat);
            checks++; if (got !== 16'sd0) begin errors++; $display("FAIL impulse_zero: got %0d, required 0", got); end
        end
    endtask

    task automatic test_moving_average();
        logic signed [15:0] got;
        int lat;
        pulse_reset(1);
        load_set(3, 16'sh0800, 16'sh0800, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            send(16'sd1600, 3, 1'b1);
            get_out("ma", got, lat);
            checks++;
            if (got !== 16'(100 * i)) begin
                errors++;
                $display("FAIL ma_step: sample %0d got %0d, required %0d", i, got, 100 * i);
            end
        end
    endtask

    task automatic test_saturation();
        logic signed [15:0] got;
        int lat;
        load_set(1, 16'sh7FFF, 16'sh7FFF, 1'b0);
        for (int i = 0; i < 16; i++) begin
            send(16'sd32767, 1, 1'b1);
            get_out("sat_pos", got, lat);
        end
        checks++; if (got !== 16'sd32767) begin errors++; $display("FAIL sat_pos_clamp: got %0d, required 32767", got); end
        for (int i = 0; i < 16; i++) begin
            send(-16'sd32768, 1, 1'b1);
            get_out("sat_neg", got, lat);
        end
        checks++; if (got !== -16'sd32768) begin errors++; $display("FAIL sat_neg_clamp: got %0d, required -32768", got); end
    endtask

    task automatic test_bandpass();
        logic signed [15:0] got;
        int lat;
        logic signed [15:0] d;
        load_set(2, 16'sh2000, 16'sh2000, 1'b1);
        for (int i = 0; i < 8; i++) begin
            d = 16'($urandom_range(0, 65535));
            send(d, 2, 1'b1);
            get_out("bandpass", got, lat);
        end
    endtask

    task automatic test_backpressure();
        logic signed [15:0] held;
        logic signed [15:0] e;
        int n;
        @(negedge clk);
        out_ready = 1'b0;
        send(16'sd800, 3, 1'b1);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL bp_timeout: out_valid=%0b, required 1", out_valid);
        end else begin
            e = exp_q.pop_front();
            held = out_data;
            checks++; if (held !== e) begin errors++; $display("FAIL bp_data: got %0d, required %0d", held, e); end
            in_valid = 1'b1;
            in_data = 16'sd12345;
            coef_we = 1'b1;
            coef_mode = 2'd2;
            coef_idx = 4'd1;
            coef_data = 16'sh7777;
            #1;
            checks++; if (coef_busy !== 1'b1) begin errors++; $display("FAIL bp_coef_busy: got %0b, required 1", coef_busy); end
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid: cycle %0d got %0b, required 1", i, out_valid); end
                checks++; if (out_data !== held) begin errors++; $display("FAIL bp_hold_data: cycle %0d got %0d, required %0d", i, out_data, held); end
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: cycle %0d got %0b, required 0", i, in_ready); end
            end
            in_valid = 1'b0;
            coef_we = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk);
        // The ignored sample must not have entered the history
        begin
            logic signed [15:0] got;
            int lat;
            send(16'sd1600, 3, 1'b1);
            get_out("bp_after", got, lat);
        end
    endtask

    task automatic test_abort_collision();
        logic signed [15:0] got;
        int lat;
        bit saw_valid;
        bit saw_busy;
        send(16'sd500, 3, 1'b0);
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        saw_valid = 1'b0;
        saw_busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid !== 1'b0) saw_valid = 1'b1;
            if (in_ready !== 1'b1) saw_busy = 1'b1;
            @(negedge clk);
        end
        checks++; if (saw_valid) begin errors++; $display("FAIL abort_out_valid: got 1 after reset, required 0"); end
        checks++; if (saw_busy) begin errors++; $display("FAIL abort_in_ready: got 0 after reset, required 1"); end
        send(16'sd1600, 3, 1'b1);
        get_out("abort_clean", got, lat);
        checks++; if (got !== 16'sd100) begin errors++; $display("FAIL abort_history: got %0d, required 100", got); end

        // Sample and coefficient write in the same IDLE cycle
        @(negedge clk);
        in_valid = 1'b1;
        in_data = 16'sd2000;
        in_mode = 2'd0;
        coef_we = 1'b1;
        coef_mode = 2'd0;
        coef_idx = 4'd0;
        coef_data = 16'sh1234;
        #1;
        checks++; if (coef_busy !== 1'b1) begin errors++; $display("FAIL collide_busy: got %0b, required 1", coef_busy); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        coef_we = 1'b0;
        t_acc = cyc;
        model_accept(16'sd2000, 0, 1'b1);
        get_out("collide", got, lat);
        checks++; if (got !== 16'sd2000) begin errors++; $display("FAIL collide_coef_kept: got %0d, required 2000", got); end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_impulse();
        test_moving_average();
        test_saturation();
        test_bandpass();
        test_backpressure();
        test_abort_collision();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results outstanding, required 0", exp_q.size());
        end
        checks++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
